// File: rtl/ling_lf_subtractor_pipe.sv
// ling_lf_subtractor_pipe
//   Two-stage pipelined subtractor: o_diff = i_a - i_b - i_bin (mod 2^W).
//   Computed as a + ~b + ~bin on a Ling-form Ladner-Fischer prefix tree. The tree
//   produces pseudo-carries H, and true carries are recovered as c = p & H.
//   The first SPLIT prefix levels run before the stage-1 register. The remaining
//   levels and the sum/flag logic run before the stage-2 (output) register.
//   Valid/ready handshake on both sides, 1 beat/cycle, no bubbles when full.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous reset, active-high
//   i_in_valid   operand beat offered
//   o_in_ready   beat can be accepted this cycle (combinational from i_out_ready)
//   i_a, i_b     minuend / subtrahend, W bits
//   i_bin        borrow in
//   o_out_valid  result beat present
//   i_out_ready  consumer takes the result this cycle
//   o_diff       a - b - bin, modulo 2^W
//   o_bout       borrow out: unsigned a < b + bin
//   o_zero       o_diff == 0
//   o_ovf        signed overflow of the subtraction
module ling_lf_subtractor_pipe #(
    parameter int unsigned W     = 26,
    parameter int unsigned SPLIT = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_diff,
    output logic         o_bout,
    output logic         o_zero,
    output logic         o_ovf
);

    // Position 0 of the prefix vectors carries ~bin; positions 1..W are operand bits.
    localparam int N       = W + 1;
    localparam int LVLS    = $clog2(N);
    localparam int S1_LVLS = (int'(SPLIT) < LVLS) ? int'(SPLIT) : LVLS;
    // After S1_LVLS levels, positions below ILO already span down to position 0,
    // so their group-propagate terms are never consulted again.
    localparam int ILO     = (1 << S1_LVLS) - 1;
    localparam int IW      = N - ILO;

    // Runs Ling prefix levels [lvl_lo, lvl_hi) on (h, i) group pairs.
    // A group [k:j] holds h = pseudo-carry assuming none enters below j, and
    // i = p[k-1] & ... & p[j-1]; combine: h = hh | ih & hl, i = ih & il.
    function automatic void prefix_levels(
        input  logic [N-1:0] h_in,
        input  logic [N-1:0] i_in,
        input  int           lvl_lo,
        input  int           lvl_hi,
        output logic [N-1:0] h_out,
        output logic [N-1:0] i_out
    );
        logic [N-1:0] h_cur, i_cur, h_nxt, i_nxt;
        int           j;
        h_cur = h_in;
        i_cur = i_in;
        for (int l = 0; l < LVLS; l++) begin
            if (l >= lvl_lo && l < lvl_hi) begin
                h_nxt = h_cur;
                i_nxt = i_cur;
                for (int k = 0; k < N; k++) begin
                    if (((k >> l) & 1) == 1) begin
                        j        = ((k >> l) << l) - 1;
                        h_nxt[k] = h_cur[k] | (i_cur[k] & h_cur[j]);
                        i_nxt[k] = i_cur[k] & i_cur[j];
                    end
                end
                h_cur = h_nxt;
                i_cur = i_nxt;
            end
        end
        h_out = h_cur;
        i_out = i_cur;
    endfunction

    // Stage-1 levels: returns {H, I[N-1:ILO]}.
    function automatic logic [N+IW-1:0] s1_prefix(
        input logic [N-1:0] p,
        input logic [N-1:0] g
    );
        logic [N-1:0] h_o, i_o;
        // A lone position's Ling propagate is the p of the position below it;
        // nothing lies below the carry-in slot.
        prefix_levels(g, {p[N-2:0], 1'b0}, 0, S1_LVLS, h_o, i_o);
        return {h_o, i_o[N-1:ILO]};
    endfunction

    // Stage-2 levels: returns the final H[k:0] for every position.
    function automatic logic [N-1:0] s2_prefix(
        input logic [N-1:0]  h,
        input logic [IW-1:0] i_hi
    );
        logic [N-1:0] i_full, h_o, i_o;
        i_full         = '0;
        i_full[N-1:ILO] = i_hi;
        prefix_levels(h, i_full, S1_LVLS, LVLS, h_o, i_o);
        return h_o;
    endfunction

    // Handshake
    logic w_s2_adv, w_in_fire;
    logic r_s1_valid, r_out_valid;

    assign w_s2_adv    = !r_out_valid || i_out_ready;
    assign o_in_ready  = !r_s1_valid || w_s2_adv;
    assign w_in_fire   = i_in_valid && o_in_ready;
    assign o_out_valid = r_out_valid;

    // Stage-1 combinational: pre-compute on ~b and the first prefix levels
    logic [N-1:0]    w_p, w_g;
    logic [N+IW-1:0] w_s1;

    assign w_p  = {i_a | ~i_b, 1'b1};
    assign w_g  = {i_a & ~i_b, ~i_bin};
    assign w_s1 = s1_prefix(w_p, w_g);

    logic [N-1:0]  r_p, r_h;
    logic [W-1:0]  r_g;
    logic [IW-1:0] r_i;
    logic          r_sa, r_sb;

    // Stage-2 combinational: finish prefix, post-compute
    logic [N-1:0] w_hf, w_carry;
    logic [W-1:0] w_t, w_diff;
    logic         w_bout, w_zero, w_ovf;

    assign w_hf    = s2_prefix(r_h, r_i);
    assign w_carry = r_p & w_hf;               // w_carry[k]: carry out of position k
    assign w_t     = r_p[N-1:1] & ~r_g;        // a ^ ~b
    assign w_diff  = w_t ^ w_carry[N-2:0];
    assign w_bout  = ~w_carry[N-1];
    assign w_zero  = (w_diff == '0);
    assign w_ovf   = (r_sa != r_sb) && (w_diff[W-1] != r_sa);

    logic [W-1:0] r_diff;
    logic         r_bout, r_zero, r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_p         <= '0;
            r_g         <= '0;
            r_h         <= '0;
            r_i         <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_p        <= w_p;
                r_g        <= w_g[N-1:1];
                r_h        <= w_s1[N+IW-1:IW];
                r_i        <= w_s1[IW-1:0];
                r_sa       <= i_a[W-1];
                r_sb       <= i_b[W-1];
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_diff <= w_diff;
                    r_bout <= w_bout;
                    r_zero <= w_zero;
                    r_ovf  <= w_ovf;
                end
            end
        end
    end

    assign o_diff = r_diff;
    assign o_bout = r_bout;
    assign o_zero = r_zero;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_ling_lf_subtractor_pipe.sv
// Self-checking bench for ling_lf_subtractor_pipe: directed corner cases,
// back-pressure, mid-flight reset and a long randomized run against a
// plain-arithmetic reference model with an in-order scoreboard.
module tb_ling_lf_subtractor_pipe;

    localparam int W = 26;
    localparam logic [W-1:0] MASK = '1;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_bin;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [W-1:0] o_diff;
    logic         o_bout;
    logic         o_zero;
    logic         o_ovf;

    ling_lf_subtractor_pipe #(
        .W     (W),
        .SPLIT (2)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_bin       (i_bin),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_diff      (o_diff),
        .o_bout      (o_bout),
        .o_zero      (o_zero),
        .o_ovf       (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } res_t;

    res_t         exp_q[$];
    logic [W-1:0] got_q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           n_acc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
        res_t   r;
        longint d;
        d      = longint'(a) - longint'(b) - longint'(bin);
        r.diff = d[W-1:0];
        r.bout = (d < 0);
        r.zero = (r.diff == '0);
        r.ovf  = (a[W-1] != b[W-1]) && (r.diff[W-1] != a[W-1]);
        return r;
    endfunction

    // Called at posedge+1 after the inputs for the coming edge are set.
    task automatic step();
        res_t e;
        #2;
        check_val("in_ready", {31'd0, o_in_ready}, {31'd0, (exp_q.size() < 2) || i_out_ready});
        if (o_out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_out_valid", {31'd0, o_out_valid}, 32'd0);
            end else begin
                e = exp_q[0];
                check_val("diff", o_diff, e.diff);
                check_val("bout", {31'd0, o_bout}, {31'd0, e.bout});
                check_val("zero", {31'd0, o_zero}, {31'd0, e.zero});
                check_val("ovf", {31'd0, o_ovf}, {31'd0, e.ovf});
                if (i_out_ready) begin
                    void'(exp_q.pop_front());
                    got_q.push_back(o_diff);
                end
            end
        end
        if (i_in_valid && o_in_ready) begin
            exp_q.push_back(ref_model(i_a, i_b, i_bin));
            n_acc++;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic bin, input logic [W-1:0] ed, input logic eb,
                            input logic ez, input logic eo);
        i_in_valid  = 1'b1;
        i_a         = a;
        i_b         = b;
        i_bin       = bin;
        i_out_ready = 1'b1;
        #1;
        check_val({tag, "_in_ready"}, {31'd0, o_in_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        check_val({tag, "_valid_early"}, {31'd0, o_out_valid}, 32'd0);
        @(posedge i_clk);
        #1;
        check_val({tag, "_valid"}, {31'd0, o_out_valid}, 32'd1);
        check_val({tag, "_diff"}, o_diff, ed);
        check_val({tag, "_bout"}, {31'd0, o_bout}, {31'd0, eb});
        check_val({tag, "_zero"}, {31'd0, o_zero}, {31'd0, ez});
        check_val({tag, "_ovf"}, {31'd0, o_ovf}, {31'd0, eo});
        @(posedge i_clk);
        #1;
        check_val({tag, "_valid_after"}, {31'd0, o_out_valid}, 32'd0);
    endtask

    initial begin
        int beat;
        int acc_before;
        int start;
        int cyc;

        i_rst       = 1'b1;
        i_in_valid  = 1'b0;
        i_a         = '0;
        i_b         = '0;
        i_bin       = 1'b0;
        i_out_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        check_val("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        check_val("rst_diff", o_diff, 32'd0);
        check_val("rst_flags", {29'd0, o_bout, o_zero, o_ovf}, 32'd0);
        check_val("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
        @(posedge i_clk);
        #1;

        // Directed corner cases
        directed("t1", 26'd5, 26'd3, 1'b0, 26'd2, 1'b0, 1'b0, 1'b0);
        directed("t2", 26'd0, 26'd1, 1'b0, 26'h3FFFFFF, 1'b1, 1'b0, 1'b0);
        directed("t2z", 26'd7, 26'd7, 1'b0, 26'd0, 1'b0, 1'b1, 1'b0);
        directed("t3", 26'h2000000, 26'd1, 1'b0, 26'h1FFFFFF, 1'b0, 1'b0, 1'b1);
        directed("t3b", 26'd3, 26'd3, 1'b1, 26'h3FFFFFF, 1'b1, 1'b0, 1'b0);

        // Back-pressure: beats 1..5, consumer stalled in cycles 2..6
        got_q.delete();
        beat = 1;
        for (int c = 1; c <= 20; c++) begin
            i_out_ready = !(c >= 2 && c <= 6);
            i_in_valid  = (beat <= 5);
            i_a         = W'(10 * beat);
            i_b         = W'(beat);
            i_bin       = 1'b0;
            acc_before  = n_acc;
            step();
            if (n_acc != acc_before) beat++;
        end
        check_val("bp_count", got_q.size(), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got_q.size()) check_val("bp_order", got_q[k], 32'(9 * (k + 1)));
        end
        check_val("bp_drained", exp_q.size(), 32'd0);

        // Reset with both stages full
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        i_a = 26'd100; i_b = 26'd1; i_bin = 1'b0;
        step();
        i_a = 26'd200; i_b = 26'd2;
        step();
        i_in_valid = 1'b0;
        #1;
        check_val("full_out_valid", {31'd0, o_out_valid}, 32'd1);
        check_val("full_in_ready", {31'd0, o_in_ready}, 32'd0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_q.delete();
        #1;
        check_val("rst2_out_valid", {31'd0, o_out_valid}, 32'd0);
        check_val("rst2_diff", o_diff, 32'd0);
        check_val("rst2_flags", {29'd0, o_bout, o_zero, o_ovf}, 32'd0);
        check_val("rst2_in_ready", {31'd0, o_in_ready}, 32'd1);
        i_out_ready = 1'b1;
        repeat (4) step();

        // Randomized traffic
        start = n_acc;
        cyc   = 0;
        while (n_acc < start + 10000 && cyc < 60000) begin
            i_in_valid = ($urandom_range(0, 3) != 0);
            i_a        = W'($urandom);
            case ($urandom_range(0, 7))
                0:       i_b = i_a;
                1:       i_b = i_a + 26'd1;
                2:       i_b = '0;
                3:       i_b = MASK;
                4:       i_b = i_a ^ 26'h2000000;
                default: i_b = W'($urandom);
            endcase
            i_bin       = 1'($urandom_range(0, 1));
            i_out_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        check_val("rand_beats", n_acc - start, 32'd10000);

        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        repeat (6) step();
        check_val("final_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
